// File: rtl/round_robin_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: requester count,
// hold counter width, FSM state encoding and a one-hot decode helper.
package round_robin_arbiter_4_pkg;

    localparam int N_REQ  = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot_of(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_4_pick.sv
// Rotating priority pick: the first asserted request at or after ptr
// (wrapping mod 4) wins. Purely combinational.
module rr_pick_4
    import round_robin_arbiter_4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             valid,
    output logic [1:0]       idx
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [1:0]         offset;

    always_comb begin
        // Rotating right by ptr puts the highest-priority requester at bit 0.
        doubled = {req, req} >> ptr;
        rotated = doubled[N_REQ-1:0];
        valid   = 1'b0;
        offset  = 2'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                valid  = 1'b1;
                offset = 2'(i);
            end
        end
        idx = ptr + offset;
    end

endmodule

// File: rtl/round_robin_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant, a bounded
// hold time per owner and a one-cycle preempt pulse on timeout.
module round_robin_arbiter_4
    import round_robin_arbiter_4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       gnt_id,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q,    state_d;
    logic [1:0]        ptr_q,      ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]  gnt_q,      gnt_d;
    logic [1:0]        gnt_id_q,   gnt_id_d;
    logic              preempt_q,  preempt_d;

    logic [N_REQ-1:0]  owner_mask;
    logic              owner_req;
    logic              timeout;
    logic              release_now;
    logic [1:0]        next_ptr;
    logic [N_REQ-1:0]  pick_req;
    logic [1:0]        pick_ptr;
    logic              pick_valid;
    logic [1:0]        pick_idx;

    always_comb begin
        owner_mask  = onehot_of(gnt_id_q);
        owner_req   = |(req & owner_mask);
        timeout     = (hold_cnt_q == HOLD_LAST);
        release_now = (state_q == ST_BUSY) && (!owner_req || timeout);
        next_ptr    = gnt_id_q + 2'd1;
        // While busy the pick only matters on release, where the outgoing
        // owner is masked so a timed-out hog cannot win its own handover.
        if (state_q == ST_BUSY) begin
            pick_req = req & ~owner_mask;
            pick_ptr = next_ptr;
        end else begin
            pick_req = req;
            pick_ptr = ptr_q;
        end
    end

    rr_pick_4 u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        preempt_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_BUSY;
                    gnt_d      = onehot_of(pick_idx);
                    gnt_id_d   = pick_idx;
                    hold_cnt_d = '0;
                end
            end

            ST_BUSY: begin
                if (release_now) begin
                    ptr_d      = next_ptr;
                    preempt_d  = timeout && owner_req;
                    hold_cnt_d = '0;
                    if (pick_valid) begin
                        gnt_d    = onehot_of(pick_idx);
                        gnt_id_d = pick_idx;
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        gnt_id_d = 2'd0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= 2'd0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            preempt_q  <= preempt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Directed bench for round_robin_arbiter_4: one instance with MAX_HOLD=8 and
// one with MAX_HOLD=4 share clock and reset.
module tb_round_robin_arbiter_4;

    logic       clk;
    logic       reset;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] gnt_id_a, gnt_id_b;
    logic       gnt_valid_a, gnt_valid_b;
    logic       preempt_a, preempt_b;

    int checks   = 0;
    int failures = 0;

    round_robin_arbiter_4 #(.MAX_HOLD(8)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .req       (req_a),
        .gnt       (gnt_a),
        .gnt_id    (gnt_id_a),
        .gnt_valid (gnt_valid_a),
        .preempt   (preempt_a)
    );

    round_robin_arbiter_4 #(.MAX_HOLD(4)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .req       (req_b),
        .gnt       (gnt_b),
        .gnt_id    (gnt_id_b),
        .gnt_valid (gnt_valid_b),
        .preempt   (preempt_b)
    );

    always #5 clk = ~clk;

    // {gnt, gnt_id (zeroed when no owner), gnt_valid, preempt}
    function automatic logic [7:0] obs(input logic [3:0] g, input logic [1:0] id,
                                       input logic v, input logic p);
        return {g, (v ? id : 2'b00), v, p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        reset = 1'b1;
        req_a = 4'b1111;
        req_b = 4'b1111;
        step();
        step();
        got = {gnt_a, gnt_id_a, gnt_valid_a, preempt_a};
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL reset_a got=%b want=%b", got, 8'h00);
        end
        got = {gnt_b, gnt_id_b, gnt_valid_b, preempt_b};
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL reset_b got=%b want=%b", got, 8'h00);
        end
        req_a = 4'b0000;
        req_b = 4'b0000;
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] got;
        do_reset();
        req_a = 4'b0100;
        step();
        got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
        checks++;
        if (got !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL single_grant got=%b want=%b", got, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        req_a = 4'b0000;
        step();
        got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL single_release got=%b want=%b", got, 8'h00);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] got, want;
        logic [1:0] o, n;
        do_reset();
        req_a = 4'b1111;
        step();
        got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
        checks++;
        if (got !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rot_first got=%b want=%b", got, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            o = 2'(i);
            n = o + 2'd1;
            req_a = 4'b1111;
            step();
            got  = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
            want = {4'b0001 << o, o, 1'b1, 1'b0};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL rot_hold%0d got=%b want=%b", i, got, want);
            end
            req_a = 4'b1111 & ~(4'b0001 << o);
            step();
            got  = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
            want = {4'b0001 << n, n, 1'b1, 1'b0};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL rot_handover%0d got=%b want=%b", i, got, want);
            end
        end
        req_a = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        logic [7:0] got;
        do_reset();
        req_a = 4'b0011;
        for (int c = 1; c <= 8; c++) begin
            step();
            got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
            checks++;
            if (got !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL to_hold0_c%0d got=%b want=%b", c, got, {4'b0001, 2'd0, 1'b1, 1'b0});
            end
        end
        step();
        got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
        checks++;
        if (got !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL to_preempt0 got=%b want=%b", got, {4'b0010, 2'd1, 1'b1, 1'b1});
        end
        for (int c = 2; c <= 8; c++) begin
            step();
            got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
            checks++;
            if (got !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL to_hold1_c%0d got=%b want=%b", c, got, {4'b0010, 2'd1, 1'b1, 1'b0});
            end
        end
        step();
        got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
        checks++;
        if (got !== {4'b0001, 2'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL to_preempt1 got=%b want=%b", got, {4'b0001, 2'd0, 1'b1, 1'b1});
        end
        req_a = 4'b0000;
        step();
        got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL to_voluntary_idle got=%b want=%b", got, 8'h00);
        end
    endtask

    task automatic test_lone_hog();
        logic [7:0] got;
        do_reset();
        req_b = 4'b1000;
        for (int c = 1; c <= 4; c++) begin
            step();
            got = obs(gnt_b, gnt_id_b, gnt_valid_b, preempt_b);
            checks++;
            if (got !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL hog_hold_c%0d got=%b want=%b", c, got, {4'b1000, 2'd3, 1'b1, 1'b0});
            end
        end
        step();
        got = obs(gnt_b, gnt_id_b, gnt_valid_b, preempt_b);
        checks++;
        if (got !== {4'b0000, 2'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL hog_preempt got=%b want=%b", got, {4'b0000, 2'd0, 1'b0, 1'b1});
        end
        step();
        got = obs(gnt_b, gnt_id_b, gnt_valid_b, preempt_b);
        checks++;
        if (got !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL hog_regrant got=%b want=%b", got, {4'b1000, 2'd3, 1'b1, 1'b0});
        end
    endtask

    // Runs straight after the hog test: owner 3 holds the grant.
    task automatic test_wraparound();
        logic [7:0] got;
        req_b = 4'b0101;
        step();
        got = obs(gnt_b, gnt_id_b, gnt_valid_b, preempt_b);
        checks++;
        if (got !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL wrap_grant got=%b want=%b", got, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
        req_b = 4'b0100;
        step();
        got = obs(gnt_b, gnt_id_b, gnt_valid_b, preempt_b);
        checks++;
        if (got !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL wrap_next got=%b want=%b", got, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        req_b = 4'b0000;
        step();
        got = obs(gnt_b, gnt_id_b, gnt_valid_b, preempt_b);
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL wrap_idle got=%b want=%b", got, 8'h00);
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] got;
        do_reset();
        req_a = 4'b0100;
        step();
        got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
        checks++;
        if (got !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL midrst_pre got=%b want=%b", got, {4'b0100, 2'd2, 1'b1, 1'b0});
        end
        req_a = 4'b0110;
        reset = 1'b1;
        step();
        got = {gnt_a, gnt_id_a, gnt_valid_a, preempt_a};
        checks++;
        if (got !== 8'h00) begin
            failures++;
            $display("FAIL midrst_clear got=%b want=%b", got, 8'h00);
        end
        reset = 1'b0;
        step();
        got = obs(gnt_a, gnt_id_a, gnt_valid_a, preempt_a);
        checks++;
        if (got !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL midrst_regrant got=%b want=%b", got, {4'b0010, 2'd1, 1'b1, 1'b0});
        end
        req_a = 4'b0000;
        step();
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_lone_hog();
        test_wraparound();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
